// File: rtl/lane_striper_n.sv
// lane_striper_n: gathers a transmit byte stream into lane groups of
// 2^link_width bytes and presents each completed group on per-lane
// outputs with a ready/valid handshake. While the link is inactive, bytes
// bypass the striper and appear on the recirculation port one cycle later.
//
// Optional feature macro: STRIPE_PAD_EN
//   defined   - a partial group left behind when 'active' drops is padded
//               with PAD and emitted as a full group of the latched width.
//   undefined - a partial group is discarded when 'active' drops.
module lane_striper_n #(
    parameter int WIDTH = 8,
    parameter int LANES_LOG2 = 2,
    parameter logic [WIDTH-1:0] PAD = 8'hF7,
    localparam int LANES = 1 << LANES_LOG2
) (
    input  logic                     clk4f,
    input  logic                     reset,
    input  logic                     active,
    input  logic [LANES_LOG2:0]      link_width,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [LANES-1:0]         out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         recir_data,
    output logic                     recir_valid
);

    // Counters and widths share one size so that a lane count of LANES
    // (one more than the largest pointer) is representable.
    localparam int CW = LANES_LOG2 + 1;

    logic [LANES-1:0][WIDTH-1:0] asm_q, asm_d;
    logic [CW-1:0]               ptr_q, ptr_d;
    logic [CW-1:0]               curW_q, curW_d;
    logic [LANES-1:0][WIDTH-1:0] outData_q, outData_d;
    logic [LANES-1:0]            outValid_q, outValid_d;
    logic                        outFull_q, outFull_d;
    logic [WIDTH-1:0]            recirData_q, recirData_d;
    logic                        recirValid_q, recirValid_d;

    logic                        flushPending;
`ifdef STRIPE_PAD_EN
    logic                        flushPending_q, flushPending_d;
    assign flushPending = flushPending_q;
`else
    logic [WIDTH-1:0]            unusedPad;
    assign flushPending = 1'b0;
    assign unusedPad    = PAD;
`endif

    logic [CW-1:0]               clampW;
    logic [CW-1:0]               effW;
    logic [CW-1:0]               laneCount;
    logic [CW-1:0]               lastIdx;
    logic                        lastSlot;
    logic                        outFree;
    logic [LANES-1:0]            laneMask;
    logic                        accept;
    logic [LANES-1:0][WIDTH-1:0] groupData;

    // Width of the group being assembled: a fresh group picks up the
    // clamped link width, a group already in progress keeps its width.
    always_comb begin
        clampW    = (link_width > CW'(LANES_LOG2)) ? CW'(LANES_LOG2) : link_width;
        effW      = ((ptr_q == '0) && !flushPending) ? clampW : curW_q;
        laneCount = CW'(1) << effW;
        lastIdx   = laneCount - CW'(1);
        lastSlot  = (ptr_q == lastIdx);
        outFree   = !outFull_q || out_ready;
        laneMask  = '0;
        for (int i = 0; i < LANES; i++) begin
            laneMask[i] = (CW'(i) < laneCount);
        end
        if (reset) begin
            in_ready = 1'b0;
        end else if (!active) begin
            in_ready = 1'b1;
        end else begin
            in_ready = !flushPending && (!lastSlot || outFree);
        end
        accept = active && in_valid && in_ready;
    end

    // Group as it would look if the incoming byte completed it: earlier
    // slots from the assembly register, the current slot from the input,
    // everything else (including lanes beyond the width) forced to zero.
    always_comb begin
        groupData = '0;
        for (int i = 0; i < LANES; i++) begin
            if (laneMask[i]) begin
                if (CW'(i) < ptr_q) begin
                    groupData[i] = asm_q[i];
                end else if (CW'(i) == ptr_q) begin
                    groupData[i] = in_data;
                end
            end
        end
    end

    // Next-state logic for assembly, output holding register and the
    // recirculation register.
    always_comb begin
        asm_d        = asm_q;
        ptr_d        = ptr_q;
        curW_d       = effW;
        outData_d    = outData_q;
        outValid_d   = outValid_q;
        outFull_d    = outFull_q;
        recirData_d  = recirData_q;
        recirValid_d = 1'b0;
`ifdef STRIPE_PAD_EN
        flushPending_d = flushPending_q;
`endif

        if (!active) begin
            recirValid_d = in_valid;
            if (in_valid) begin
                recirData_d = in_data;
            end
            ptr_d = '0;
`ifdef STRIPE_PAD_EN
            if (ptr_q != '0) begin
                for (int i = 0; i < LANES; i++) begin
                    if (CW'(i) >= ptr_q) begin
                        asm_d[i] = PAD;
                    end
                end
                flushPending_d = 1'b1;
            end
`endif
        end else if (accept) begin
            if (lastSlot) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + CW'(1);
                for (int i = 0; i < LANES; i++) begin
                    if (CW'(i) == ptr_q) begin
                        asm_d[i] = in_data;
                    end
                end
            end
        end

        if (outFull_q && out_ready) begin
            outFull_d  = 1'b0;
            outValid_d = '0;
        end

        if (accept && lastSlot) begin
            outData_d  = groupData;
            outValid_d = laneMask;
            outFull_d  = 1'b1;
        end

`ifdef STRIPE_PAD_EN
        if (flushPending_q && outFree) begin
            for (int i = 0; i < LANES; i++) begin
                outData_d[i] = laneMask[i] ? asm_q[i] : '0;
            end
            outValid_d     = laneMask;
            outFull_d      = 1'b1;
            flushPending_d = 1'b0;
        end
`endif
    end

    // State registers; reset discards any partial and held group at once.
    always_ff @(posedge clk4f or posedge reset) begin
        if (reset) begin
            asm_q          <= '0;
            ptr_q          <= '0;
            curW_q         <= '0;
            outData_q      <= '0;
            outValid_q     <= '0;
            outFull_q      <= 1'b0;
            recirData_q    <= '0;
            recirValid_q   <= 1'b0;
`ifdef STRIPE_PAD_EN
            flushPending_q <= 1'b0;
`endif
        end else begin
            asm_q          <= asm_d;
            ptr_q          <= ptr_d;
            curW_q         <= curW_d;
            outData_q      <= outData_d;
            outValid_q     <= outValid_d;
            outFull_q      <= outFull_d;
            recirData_q    <= recirData_d;
            recirValid_q   <= recirValid_d;
`ifdef STRIPE_PAD_EN
            flushPending_q <= flushPending_d;
`endif
        end
    end

    assign out_data    = outData_q;
    assign out_valid   = outValid_q;
    assign recir_data  = recirData_q;
    assign recir_valid = recirValid_q;

endmodule

// File: tb/tb_lane_striper_n.sv
// Bench for lane_striper_n (4 lanes, 8-bit bytes): a vector table for the
// basic striping, width and recirculation cases, hand sequences for reset
// and link-drop corners, and a randomized run against a queue-based model.
`timescale 1ns/1ps
module tb_lane_striper_n;

    localparam int LANES_LOG2 = 2;
    localparam int LANES = 4;
    localparam logic [7:0] PADB = 8'hF7;

    logic        clk4f = 1'b0;
    logic        reset;
    logic        active;
    logic [2:0]  link_width;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic        out_ready;
    logic [7:0]  recir_data;
    logic        recir_valid;

    int assertCount = 0;
    int failCount = 0;

    lane_striper_n #(.WIDTH(8), .LANES_LOG2(LANES_LOG2), .PAD(8'hF7)) dut (
        .clk4f(clk4f), .reset(reset), .active(active), .link_width(link_width),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .recir_data(recir_data), .recir_valid(recir_valid)
    );

    // Free-running transmit clock.
    always #5 clk4f = ~clk4f;

    // Reference model: bytes of the open group in a queue, the held group
    // as an array, plus the recirculation byte.
    logic [7:0] mPart[$];
    int         mGw;
    bit         mFlush;
    bit         mFull;
    logic [7:0] mData[LANES];
    logic [3:0] mValid;
    bit         mRV;
    logic [7:0] mRD;

    typedef struct {
        bit          act;
        logic [2:0]  lw;
        logic [7:0]  din;
        bit          vin;
        bit          ordy;
        bit          eRdy;
        logic [3:0]  eOV;
        logic [31:0] eOD;
        bit          eRV;
        logic [7:0]  eRD;
    } vec_t;

    vec_t vecs[$];

    task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int clampLanes(input logic [2:0] lw);
        if (lw > 3'(LANES_LOG2)) return LANES;
        return 1 << lw;
    endfunction

    function automatic int groupLanes();
        if (mPart.size() == 0 && !mFlush) return clampLanes(link_width);
        return mGw;
    endfunction

    function automatic bit modelReady();
        if (reset) return 1'b0;
        if (!active) return 1'b1;
        if (mFlush) return 1'b0;
        if ((mPart.size() == groupLanes() - 1) && mFull && !out_ready) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] modelData();
        logic [31:0] d;
        for (int i = 0; i < LANES; i++) d[i*8 +: 8] = mData[i];
        return d;
    endfunction

    task automatic modelReset();
        mPart.delete();
        mGw = 1;
        mFlush = 1'b0;
        mFull = 1'b0;
        for (int i = 0; i < LANES; i++) mData[i] = 8'h00;
        mValid = 4'h0;
        mRV = 1'b0;
        mRD = 8'h00;
    endtask

    task automatic emitGroup();
        for (int i = 0; i < LANES; i++) mData[i] = (i < mPart.size()) ? mPart[i] : 8'h00;
        mValid = 4'h0;
        for (int i = 0; i < mGw; i++) mValid[i] = 1'b1;
        mFull = 1'b1;
        mPart.delete();
    endtask

    task automatic modelStep();
        bit rdy;
        bit free;
        bit oldFlush;
        rdy = modelReady();
        free = !mFull || out_ready;
        oldFlush = mFlush;
        if (mFull && out_ready) begin
            mFull = 1'b0;
            mValid = 4'h0;
        end
        if (!active) begin
            mRV = in_valid;
            if (in_valid) mRD = in_data;
            if (mPart.size() > 0) begin
`ifdef STRIPE_PAD_EN
                while (mPart.size() < mGw) mPart.push_back(PADB);
                mFlush = 1'b1;
`else
                mPart.delete();
`endif
            end
        end else begin
            mRV = 1'b0;
            if (mPart.size() == 0 && !mFlush) mGw = clampLanes(link_width);
            if (in_valid && rdy) begin
                mPart.push_back(in_data);
                if (mPart.size() == mGw) emitGroup();
            end
        end
        if (oldFlush && free) begin
            emitGroup();
            mFlush = 1'b0;
        end
    endtask

    task automatic checkOutput();
        checkValue("out_valid", out_valid, mValid);
        if (mValid != 4'h0) checkValue("out_data", out_data, modelData());
        checkValue("recir_valid", recir_valid, mRV);
        if (mRV) checkValue("recir_data", recir_data, mRD);
    endtask

    // One clock of stimulus: drive, check in_ready before the edge, then
    // advance the model and compare the registered outputs after the edge.
    task automatic applyStimulus(input bit a, input logic [2:0] lw, input logic [7:0] d,
                                 input bit v, input bit r, output bit rdySeen);
        active = a;
        link_width = lw;
        in_data = d;
        in_valid = v;
        out_ready = r;
        #1;
        rdySeen = in_ready;
        checkValue("in_ready", in_ready, modelReady());
        @(posedge clk4f);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic addVec(input bit a, input logic [2:0] lw, input logic [7:0] d, input bit v,
                          input bit r, input bit eRdy, input logic [3:0] eOV,
                          input logic [31:0] eOD, input bit eRV, input logic [7:0] eRD);
        vec_t t;
        t.act = a; t.lw = lw; t.din = d; t.vin = v; t.ordy = r;
        t.eRdy = eRdy; t.eOV = eOV; t.eOD = eOD; t.eRV = eRV; t.eRD = eRD;
        vecs.push_back(t);
    endtask

    initial begin
        bit rdy;
        bit act;

        // Reset state, observed while reset is still high.
        reset = 1'b1;
        active = 1'b0;
        link_width = 3'd0;
        in_data = 8'h00;
        in_valid = 1'b0;
        out_ready = 1'b0;
        modelReset();
        #3;
        checkValue("reset in_ready", in_ready, 1'b0);
        checkValue("reset out_valid", out_valid, 4'h0);
        checkValue("reset out_data", out_data, 32'h0);
        checkValue("reset recir_valid", recir_valid, 1'b0);
        checkValue("reset recir_data", recir_data, 8'h00);
        @(posedge clk4f);
        #1;
        reset = 1'b0;

        // x4 streaming, x2 on 4 lanes, recirculation, x4 backpressure.
        addVec(1, 2, 8'h00, 0, 1, 1, 4'h0, 32'h0, 0, 8'h00);
        addVec(1, 2, 8'h01, 1, 1, 1, 4'h0, 32'h0, 0, 8'h00);
        addVec(1, 2, 8'h02, 1, 1, 1, 4'h0, 32'h0, 0, 8'h00);
        addVec(1, 2, 8'h03, 1, 1, 1, 4'h0, 32'h0, 0, 8'h00);
        addVec(1, 2, 8'h04, 1, 1, 1, 4'hF, 32'h04030201, 0, 8'h00);
        addVec(1, 2, 8'h05, 1, 1, 1, 4'h0, 32'h0, 0, 8'h00);
        addVec(1, 2, 8'h06, 1, 1, 1, 4'h0, 32'h0, 0, 8'h00);
        addVec(1, 2, 8'h07, 1, 1, 1, 4'h0, 32'h0, 0, 8'h00);
        addVec(1, 2, 8'h08, 1, 1, 1, 4'hF, 32'h08070605, 0, 8'h00);
        addVec(1, 1, 8'h00, 0, 1, 1, 4'h0, 32'h0, 0, 8'h00);
        addVec(1, 1, 8'hAA, 1, 1, 1, 4'h0, 32'h0, 0, 8'h00);
        addVec(1, 1, 8'hBB, 1, 1, 1, 4'h3, 32'h0000BBAA, 0, 8'h00);
        addVec(0, 1, 8'h11, 1, 0, 1, 4'h3, 32'h0000BBAA, 1, 8'h11);
        addVec(0, 1, 8'h22, 1, 0, 1, 4'h3, 32'h0000BBAA, 1, 8'h22);
        addVec(0, 1, 8'h00, 0, 0, 1, 4'h3, 32'h0000BBAA, 0, 8'h00);
        addVec(1, 2, 8'h00, 0, 1, 1, 4'h0, 32'h0, 0, 8'h00);
        addVec(1, 2, 8'h01, 1, 0, 1, 4'h0, 32'h0, 0, 8'h00);
        addVec(1, 2, 8'h02, 1, 0, 1, 4'h0, 32'h0, 0, 8'h00);
        addVec(1, 2, 8'h03, 1, 0, 1, 4'h0, 32'h0, 0, 8'h00);
        addVec(1, 2, 8'h04, 1, 0, 1, 4'hF, 32'h04030201, 0, 8'h00);
        addVec(1, 2, 8'h05, 1, 0, 1, 4'hF, 32'h04030201, 0, 8'h00);
        addVec(1, 2, 8'h06, 1, 0, 1, 4'hF, 32'h04030201, 0, 8'h00);
        addVec(1, 2, 8'h07, 1, 0, 1, 4'hF, 32'h04030201, 0, 8'h00);
        addVec(1, 2, 8'h08, 1, 0, 0, 4'hF, 32'h04030201, 0, 8'h00);
        addVec(1, 2, 8'h08, 1, 1, 1, 4'hF, 32'h08070605, 0, 8'h00);
        addVec(1, 2, 8'h00, 0, 1, 1, 4'h0, 32'h0, 0, 8'h00);

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].act, vecs[k].lw, vecs[k].din, vecs[k].vin, vecs[k].ordy, rdy);
            checkValue($sformatf("vec%0d in_ready", k), rdy, vecs[k].eRdy);
            checkValue($sformatf("vec%0d out_valid", k), out_valid, vecs[k].eOV);
            if (vecs[k].eOV != 4'h0) checkValue($sformatf("vec%0d out_data", k), out_data, vecs[k].eOD);
            checkValue($sformatf("vec%0d recir_valid", k), recir_valid, vecs[k].eRV);
            if (vecs[k].eRV) checkValue($sformatf("vec%0d recir_data", k), recir_data, vecs[k].eRD);
        end

        // Asynchronous reset mid-clock with a held group and a partial group.
        for (int k = 0; k < 6; k++) applyStimulus(1, 2, 8'(8'h41 + k), 1, 0, rdy);
        #2;
        reset = 1'b1;
        #1;
        checkValue("midreset out_valid", out_valid, 4'h0);
        checkValue("midreset out_data", out_data, 32'h0);
        checkValue("midreset recir_valid", recir_valid, 1'b0);
        checkValue("midreset in_ready", in_ready, 1'b0);
        modelReset();
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) applyStimulus(1, 2, 8'(8'h0A + k), 1, 1, rdy);
        checkValue("postreset out_valid", out_valid, 4'hF);
        checkValue("postreset out_data", out_data, 32'h0D0C0B0A);

        // Link drop with a two-byte partial group in x4.
        applyStimulus(1, 2, 8'h00, 0, 1, rdy);
        applyStimulus(1, 2, 8'h01, 1, 1, rdy);
        applyStimulus(1, 2, 8'h02, 1, 1, rdy);
        applyStimulus(0, 2, 8'h00, 0, 1, rdy);
        applyStimulus(0, 2, 8'h00, 0, 1, rdy);
`ifdef STRIPE_PAD_EN
        checkValue("drop out_valid", out_valid, 4'hF);
        checkValue("drop out_data", out_data, 32'hF7F70201);
`else
        checkValue("drop out_valid", out_valid, 4'h0);
`endif
        applyStimulus(1, 2, 8'h00, 0, 1, rdy);
        for (int k = 0; k < 4; k++) applyStimulus(1, 2, 8'(8'h31 + k), 1, 1, rdy);
        checkValue("afterdrop out_valid", out_valid, 4'hF);
        checkValue("afterdrop out_data", out_data, 32'h34333231);

        // Randomized traffic with width changes, link drops and backpressure.
        act = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) act = !act;
            applyStimulus(act, 3'($urandom_range(0, 3)), 8'($urandom),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 4) > 1, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
